// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pkg
//  Description : Shared types, window-position constants and the signed-max
//                helper for the 2x2/stride-2 max-pooling engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Position of a datum inside its 2x2 window; bit 1 = row, bit 0 = column
    localparam logic [1:0] K_TL = 2'd0;
    localparam logic [1:0] K_TR = 2'd1;
    localparam logic [1:0] K_BL = 2'd2;
    localparam logic [1:0] K_BR = 2'd3;

    // Ties return the first argument so the accumulator keeps its value
    function automatic int signed_max(input int a, input int b);
        return (b > a) ? b : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pool_addr_gen
//  Description : Walks the input map window by window (row-major over outputs)
//                and produces the conv-buffer read address plus a last flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int IN_H  = 24,
    parameter int RD_AW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    output logic [RD_AW-1:0] addr,
    output logic [1:0]       k,
    output logic             last
);

    localparam int c_OCW = (IN_W > 2) ? $clog2(IN_W / 2) : 1;
    localparam int c_ORW = (IN_H > 2) ? $clog2(IN_H / 2) : 1;

    localparam logic [c_OCW-1:0] c_OCOL_MAX = c_OCW'(IN_W / 2 - 1);
    localparam logic [c_ORW-1:0] c_OROW_MAX = c_ORW'(IN_H / 2 - 1);
    localparam logic [c_OCW-1:0] c_OCOL_ONE = c_OCW'(1);
    localparam logic [c_ORW-1:0] c_OROW_ONE = c_ORW'(1);

    logic [c_OCW-1:0] r_ocol;
    logic [c_ORW-1:0] r_orow;
    logic [1:0]       r_k;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_ocol <= '0;
            r_orow <= '0;
            r_k    <= K_TL;
        end else if (step) begin
            r_k <= r_k + 2'd1;
            if (r_k == K_BR) begin
                if (r_ocol == c_OCOL_MAX) begin
                    r_ocol <= '0;
                    r_orow <= r_orow + c_OROW_ONE;
                end else begin
                    r_ocol <= r_ocol + c_OCOL_ONE;
                end
            end
        end
    end

    // {orow,k[1]} is the input row and {ocol,k[0]} the input column
    assign addr = RD_AW'(32'({r_orow, r_k[1]}) * IN_W + 32'({r_ocol, r_k[0]}));
    assign k    = r_k;
    assign last = (r_k == K_BR) && (r_ocol == c_OCOL_MAX) && (r_orow == c_OROW_MAX);

endmodule
`default_nettype wire

// File: rtl/pool_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pool_engine
//  Description : 2x2/stride-2 max-pooling stage with pool_en/pool_fin handshake.
//                Define POOL_RELU_EN to clamp negative pooled values to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_engine
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IN_W   = 24,
    parameter int IN_H   = 24,
    parameter int RD_AW  = 10,
    parameter int WR_AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pool_en,
    output logic              pool_fin,
    output logic              busy,
    output logic              rd_en,
    output logic [RD_AW-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [WR_AW-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    if ((IN_W % 2) != 0 || (IN_H % 2) != 0 || IN_W < 2 || IN_H < 2) begin : g_bad_dims
        $error("pool_engine: IN_W and IN_H must be even and at least 2");
    end

    localparam logic [WR_AW-1:0] c_WR_ONE = WR_AW'(1);

    state_t                     r_state;
    logic [1:0]                 r_rd_k;
    logic                       r_dv;
    logic [1:0]                 r_k_d;
    logic signed [DATA_W-1:0]   r_acc;
    logic [WR_AW-1:0]           r_wr_idx;

    logic                       w_abort;
    logic                       w_gen_clear;
    logic                       w_gen_step;
    logic [RD_AW-1:0]           w_gen_addr;
    logic [1:0]                 w_gen_k;
    logic                       w_gen_last;
    logic signed [DATA_W-1:0]   w_rd_s;
    logic signed [DATA_W-1:0]   w_max;
    logic signed [DATA_W-1:0]   w_out;

    assign w_abort     = !pool_en && (r_state == RUN || r_state == FLUSH);
    // Counters sit at zero outside a pass so a start in IDLE always begins at (0,0)
    assign w_gen_step  = pool_en && (r_state == IDLE || r_state == RUN);
    assign w_gen_clear = !pool_en || (r_state == RUN && w_gen_last)
                         || r_state == FLUSH || r_state == DONE;

    pool_addr_gen #(
        .IN_W  (IN_W),
        .IN_H  (IN_H),
        .RD_AW (RD_AW)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_gen_clear),
        .step  (w_gen_step),
        .addr  (w_gen_addr),
        .k     (w_gen_k),
        .last  (w_gen_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            pool_fin <= 1'b0;
            busy     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            r_rd_k   <= K_TL;
        end else begin
            pool_fin <= 1'b0;
            rd_en    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (pool_en) begin
                        r_state <= RUN;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= w_gen_addr;
                        r_rd_k  <= w_gen_k;
                    end
                end
                RUN: begin
                    if (!pool_en) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= w_gen_addr;
                        r_rd_k  <= w_gen_k;
                        if (w_gen_last) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!pool_en) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else if (wr_en) begin
                        // Only the final window's write can land while in FLUSH
                        r_state  <= DONE;
                        busy     <= 1'b0;
                        pool_fin <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign w_rd_s = $signed(rd_data);
    assign w_max  = (r_k_d == K_TL) ? w_rd_s
                                    : DATA_W'(signed_max(int'(r_acc), int'(w_rd_s)));

`ifdef POOL_RELU_EN
    assign w_out = w_max[DATA_W-1] ? '0 : w_max;
`else
    assign w_out = w_max;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dv     <= 1'b0;
            r_k_d    <= K_TL;
            r_acc    <= '0;
            r_wr_idx <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            r_dv  <= rd_en && !w_abort;
            r_k_d <= r_rd_k;
            if (r_state == IDLE) begin
                r_wr_idx <= '0;
            end
            if (r_dv && !w_abort) begin
                r_acc <= w_max;
                if (r_k_d == K_BR) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= r_wr_idx;
                    wr_data  <= w_out;
                    r_wr_idx <= r_wr_idx + c_WR_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_engine
//  Description : Self-checking bench for pool_engine: a 4x4 instance for
//                timing/handshake scenarios and a default 24x24 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 4x4 instance
    logic       en_s, fin_s, busy_s, rde_s, wre_s;
    logic [3:0] rda_s;
    logic [1:0] wra_s;
    logic [7:0] rdd_s, wrd_s;
    logic signed [7:0] mem_s [16];

    // 24x24 instance
    logic       en_b, fin_b, busy_b, rde_b, wre_b;
    logic [9:0] rda_b;
    logic [7:0] wra_b;
    logic [7:0] rdd_b, wrd_b;
    logic signed [7:0] mem_b [576];

    pool_engine #(.DATA_W(8), .IN_W(4), .IN_H(4), .RD_AW(4), .WR_AW(2)) u_small (
        .clk(clk), .rst_n(rst_n), .pool_en(en_s), .pool_fin(fin_s), .busy(busy_s),
        .rd_en(rde_s), .rd_addr(rda_s), .rd_data(rdd_s),
        .wr_en(wre_s), .wr_addr(wra_s), .wr_data(wrd_s)
    );

    pool_engine u_big (
        .clk(clk), .rst_n(rst_n), .pool_en(en_b), .pool_fin(fin_b), .busy(busy_b),
        .rd_en(rde_b), .rd_addr(rda_b), .rd_data(rdd_b),
        .wr_en(wre_b), .wr_addr(wra_b), .wr_data(wrd_b)
    );

    // Conv-buffer models: data valid one cycle after the read strobe
    always @(posedge clk) if (rde_s) rdd_s <= mem_s[rda_s];
    always @(posedge clk) if (rde_b) rdd_b <= mem_b[rda_b];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Per-cycle trace of the small instance, cycle 1 = first cycle after the sampling edge
    logic       tr_rde [64];
    logic [3:0] tr_rda [64];
    logic       tr_wre [64];
    logic       tr_fin [64];
    logic       tr_busy[64];
    int         wq_addr[$];
    logic [7:0] wq_data[$];
    int         wq_cyc [$];
    int         n_fin;
    int         fin_cyc;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: pooled value of output window j of the 4x4 map
    function automatic int exp_pool(input int j);
        int r, c, m, v;
        r = j / 2;
        c = j % 2;
        m = mem_s[(2 * r) * 4 + 2 * c];
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = mem_s[(2 * r + dy) * 4 + 2 * c + dx];
                if (v > m) m = v;
            end
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    // Reference: address of the i-th read in window-major order
    function automatic int exp_rd_addr(input int i);
        int j, k;
        j = i / 4;
        k = i % 4;
        return (2 * (j / 2) + k / 2) * 4 + 2 * (j % 2) + k % 2;
    endfunction

    task automatic run_small(input int ncyc, input int drop_at, input bit drop_on_fin);
        n_fin = 0;
        fin_cyc = 0;
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        en_s = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            tr_rde[c] = rde_s;  tr_rda[c] = rda_s;  tr_wre[c] = wre_s;
            tr_fin[c] = fin_s;  tr_busy[c] = busy_s;
            if (wre_s) begin
                wq_addr.push_back(int'(wra_s));
                wq_data.push_back(wrd_s);
                wq_cyc.push_back(c);
            end
            if (fin_s) begin
                n_fin++;
                fin_cyc = c;
            end
            if ((drop_on_fin && fin_s) || c == drop_at) en_s = 1'b0;
        end
        en_s = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_s = 1'b0; en_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({fin_s, busy_s, rde_s, wre_s} !== 4'b0) $display("FAIL reset_small_ctrl: got %b want 0000", {fin_s, busy_s, rde_s, wre_s});
        else pass_cnt++;
        total_cnt++;
        if ({rda_s, wra_s, wrd_s} !== 14'd0) $display("FAIL reset_small_data: got %h want 0", {rda_s, wra_s, wrd_s});
        else pass_cnt++;
        total_cnt++;
        if ({fin_b, busy_b, rde_b, wre_b, rda_b, wra_b, wrd_b} !== 30'd0) $display("FAIL reset_big: got %h want 0", {fin_b, busy_b, rde_b, wre_b, rda_b, wra_b, wrd_b});
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        logic exp_rde, exp_wre;
        for (int i = 0; i < 16; i++) mem_s[i] = 8'(i);
        run_small(24, -1, 1'b1);
        for (int c = 1; c <= 24; c++) begin
            exp_rde = (c >= 1 && c <= 16);
            exp_wre = (c >= 6 && (c - 6) % 4 == 0 && (c - 6) / 4 < 4);
            total_cnt++;
            if (tr_rde[c] !== exp_rde) $display("FAIL ramp_rd_en c=%0d: got %b want %b", c, tr_rde[c], exp_rde);
            else pass_cnt++;
            if (exp_rde) begin
                total_cnt++;
                if (int'(tr_rda[c]) !== exp_rd_addr(c - 1)) $display("FAIL ramp_rd_addr c=%0d: got %0d want %0d", c, tr_rda[c], exp_rd_addr(c - 1));
                else pass_cnt++;
            end
            total_cnt++;
            if (tr_wre[c] !== exp_wre) $display("FAIL ramp_wr_en c=%0d: got %b want %b", c, tr_wre[c], exp_wre);
            else pass_cnt++;
            total_cnt++;
            if (tr_fin[c] !== (c == 19)) $display("FAIL ramp_fin c=%0d: got %b want %b", c, tr_fin[c], (c == 19));
            else pass_cnt++;
            total_cnt++;
            if (tr_busy[c] !== (c <= 18)) $display("FAIL ramp_busy c=%0d: got %b want %b", c, tr_busy[c], (c <= 18));
            else pass_cnt++;
        end
        total_cnt++;
        if (wq_addr.size() != 4) $display("FAIL ramp_wr_count: got %0d want 4", wq_addr.size());
        else pass_cnt++;
        for (int j = 0; j < wq_addr.size() && j < 4; j++) begin
            total_cnt++;
            if (wq_addr[j] !== j || wq_data[j] !== 8'(exp_pool(j)))
                $display("FAIL ramp_write%0d: got (%0d,%0d) want (%0d,%0d)", j, wq_addr[j], wq_data[j], j, exp_pool(j));
            else pass_cnt++;
        end
    endtask

    task automatic test_negative();
        logic [7:0] want;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                mem_s[y * 4 + x] = (y % 2 == 0) ? ((x % 2 == 0) ? -8'sd3 : -8'sd8)
                                                : ((x % 2 == 0) ? -8'sd1 : -8'sd5);
`ifdef POOL_RELU_EN
        want = 8'h00;
`else
        want = 8'hFF;
`endif
        run_small(24, -1, 1'b1);
        total_cnt++;
        if (wq_data.size() != 4) $display("FAIL neg_wr_count: got %0d want 4", wq_data.size());
        else pass_cnt++;
        for (int j = 0; j < wq_data.size() && j < 4; j++) begin
            total_cnt++;
            if (wq_data[j] !== want) $display("FAIL neg_data%0d: got %h want %h", j, wq_data[j], want);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < 16; i++) mem_s[i] = 8'($urandom_range(0, 255));
            run_small(24, -1, 1'b1);
            total_cnt++;
            if (wq_data.size() != 4 || n_fin != 1 || fin_cyc != 19)
                $display("FAIL rand%0d_shape: got writes=%0d fins=%0d fin_cyc=%0d want 4/1/19", it, wq_data.size(), n_fin, fin_cyc);
            else pass_cnt++;
            for (int j = 0; j < wq_data.size() && j < 4; j++) begin
                total_cnt++;
                if (wq_addr[j] !== j || wq_data[j] !== 8'(exp_pool(j)) || wq_cyc[j] !== 4 * j + 6)
                    $display("FAIL rand%0d_write%0d: got (%0d,%h,c%0d) want (%0d,%h,c%0d)", it, j,
                             wq_addr[j], wq_data[j], wq_cyc[j], j, 8'(exp_pool(j)), 4 * j + 6);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_big();
        int nwr = 0, addr_bad = 0, data_bad = 0, last_wr = 0, bfin = 0, bfin_cyc = 0;
        int busy_first = 0, busy_last = 0, busy_n = 0;
        for (int i = 0; i < 576; i++) mem_b[i] = 8'sd127;
        mem_b[$urandom_range(0, 575)] = -8'sd128;
        en_b = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            if (wre_b) begin
                if (int'(wra_b) != nwr) addr_bad++;
                if (wrd_b !== 8'd127) data_bad++;
                nwr++;
                last_wr = c;
            end
            if (busy_b) begin
                if (busy_first == 0) busy_first = c;
                busy_last = c;
                busy_n++;
            end
            if (fin_b) begin
                bfin++;
                bfin_cyc = c;
                en_b = 1'b0;
            end
            if (bfin_cyc != 0 && c > bfin_cyc + 2) break;
        end
        en_b = 1'b0;
        total_cnt++;
        if (nwr != 144) $display("FAIL big_wr_count: got %0d want 144", nwr); else pass_cnt++;
        total_cnt++;
        if (addr_bad != 0) $display("FAIL big_wr_addr: got %0d bad want 0", addr_bad); else pass_cnt++;
        total_cnt++;
        if (data_bad != 0) $display("FAIL big_wr_data: got %0d bad want 0", data_bad); else pass_cnt++;
        total_cnt++;
        if (last_wr != 578) $display("FAIL big_last_wr: got %0d want 578", last_wr); else pass_cnt++;
        total_cnt++;
        if (bfin != 1 || bfin_cyc != 579) $display("FAIL big_fin: got %0d@%0d want 1@579", bfin, bfin_cyc); else pass_cnt++;
        total_cnt++;
        if (busy_first != 1 || busy_last != 578 || busy_n != 578)
            $display("FAIL big_busy: got %0d..%0d n=%0d want 1..578 n=578", busy_first, busy_last, busy_n);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        for (int i = 0; i < 16; i++) mem_s[i] = 8'(i);
        run_small(24, 10, 1'b0);
        total_cnt++;
        if (tr_rde[10] !== 1'b1) $display("FAIL abort_rd_before: got %b want 1", tr_rde[10]); else pass_cnt++;
        for (int c = 11; c <= 24; c++) begin
            total_cnt++;
            if ({tr_rde[c], tr_wre[c], tr_busy[c]} !== 3'b000)
                $display("FAIL abort_idle c=%0d: got %b want 000", c, {tr_rde[c], tr_wre[c], tr_busy[c]});
            else pass_cnt++;
        end
        total_cnt++;
        if (n_fin != 0) $display("FAIL abort_no_fin: got %0d want 0", n_fin); else pass_cnt++;
        run_small(24, -1, 1'b1);
        total_cnt++;
        if (wq_addr.size() != 4 || fin_cyc != 19) $display("FAIL abort_restart: got writes=%0d fin_cyc=%0d want 4/19", wq_addr.size(), fin_cyc);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int fins = 0;
        for (int i = 0; i < 16; i++) mem_s[i] = 8'(15 - i);
        en_s = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        en_s = 1'b0;
        #2;
        total_cnt++;
        if ({busy_s, rde_s} !== 2'b11) $display("FAIL rst_async_no_effect: got %b want 11", {busy_s, rde_s}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({fin_s, busy_s, rde_s, wre_s, rda_s, wra_s, wrd_s} !== 18'd0)
            $display("FAIL rst_mid_zero: got %h want 0", {fin_s, busy_s, rde_s, wre_s, rda_s, wra_s, wrd_s});
        else pass_cnt++;
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (fin_s) fins++;
        end
        total_cnt++;
        if (fins != 0) $display("FAIL rst_mid_no_fin: got %0d want 0", fins); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) mem_s[i] = 8'(i);
        run_small(30, 21, 1'b0);
        total_cnt++;
        if (n_fin != 1 || fin_cyc != 19) $display("FAIL b2b_fin: got %0d@%0d want 1@19", n_fin, fin_cyc); else pass_cnt++;
        total_cnt++;
        if ({tr_busy[20], tr_rde[20]} !== 2'b00) $display("FAIL b2b_idle: got %b want 00", {tr_busy[20], tr_rde[20]}); else pass_cnt++;
        total_cnt++;
        if ({tr_busy[21], tr_rde[21], tr_rda[21]} !== 6'b110000)
            $display("FAIL b2b_restart: got %b want 110000", {tr_busy[21], tr_rde[21], tr_rda[21]});
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_random();
        test_big();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pool_engine.md
Name: pool_engine

Overview:
- Responder side of the stage-enable/finish handshake driven by the CNN sequencing controller.
- The controller raises pool_en; this block runs 2x2/stride-2 max-pooling over one feature map in the conv output buffer and writes results to the pool buffer.
- It then returns a one-cycle pool_fin, and the controller advances to the fully-connected stage.

Parameters:
DATA_W, 8, signed pixel width
IN_W, 24, input map width (even, >=2)
IN_H, 24, input map height (even, >=2)
RD_AW, 10, read address width (2^RD_AW >= IN_W*IN_H)
WR_AW, 8, write address width (2^WR_AW >= IN_W*IN_H/4)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
pool_en  in  1  level enable from controller; high while controller is in/entering POOL
pool_fin  out  1  one-cycle done pulse
busy  out  1  high in RUN/FLUSH
rd_en  out  1  conv-buffer read strobe
rd_addr  out  RD_AW  conv-buffer address, row*IN_W+col
rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
wr_en  out  1  pool-buffer write strobe
wr_addr  out  WR_AW  pool-buffer address, orow*(IN_W/2)+ocol
wr_data  out  DATA_W  pooled value

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values: state IDLE; pool_fin, busy, rd_en and wr_en are 0; rd_addr, wr_addr and wr_data are 0. All outputs are registered.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: pool_en=1 sampled at edge T -> RUN at T+1.
  - RUN: one read issued per cycle, N=IN_W*IN_H reads total, read at cycles T+1..T+N. Goes to FLUSH after the last read is issued.
  - FLUSH: waits for the final datum and the final write. Goes to DONE once the last wr_en has been driven.
  - DONE: pool_fin=1 for exactly one cycle, then IDLE.
- Read order, per output window j (row-major over outputs): (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1). No gaps between reads, including across windows and rows.
- Accumulate:
  - Window datum k=0 loads acc.
  - k=1..3: acc = signed max(acc, rd_data).
  - Ties keep the existing value.
- Write timing:
  - wr_en for window j is registered high at T+4j+6, with wr_data = final max and wr_addr = j.
  - Writes are one-cycle pulses, at most one every 4 cycles.
- Latency: with M=N/4, the last write is at T+4M+2 and pool_fin at T+4M+3. For 24x24: last write T+578, pool_fin T+579.
- Abort: pool_en=0 sampled in RUN or FLUSH -> IDLE next cycle.
  - rd_en and wr_en are 0 from that cycle.
  - No pool_fin; partial results in the pool buffer are undefined.
- DONE with pool_en still high: pool_fin still pulses, then IDLE. A still-high pool_en in IDLE restarts the pass. The controller drops pool_en in the same cycle it sees pool_fin, so no restart occurs in normal operation.
- pool_en toggles while IDLE: only the level sampled in IDLE matters; no edge detection.
- Reset mid-pass: immediate return to reset values at the next edge; no pool_fin.
- busy = (state==RUN or FLUSH).
- Elaboration error if IN_W or IN_H is odd.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: wr_data = (max < 0) ? 0 : max, i.e. ReLU fused after pooling, with no added latency.
- Undefined: raw signed max is written.
- Timing, handshake and addresses are identical in both builds.

Decomposition:
- Package pool_pkg:
  - state enum (IDLE/RUN/FLUSH/DONE)
  - window-index constants K_TL/K_TR/K_BL/K_BR
  - signed-max function
- Sub-module pool_addr_gen:
  - ocol/orow/k counters
  - rd_addr = (2*orow + k[1])*IN_W + 2*ocol + k[0]
  - last-read flag
- Top holds the FSM, data pipeline (rd_en delay, k delay, acc) and write register.

Test Plan:
- IN_W=IN_H=4, map values 0..15, pool_en held until pool_fin:
  - writes (addr,data) = (0,5), (1,7), (2,13), (3,15);
  - pool_fin 1 cycle at T+19;
  - 16 contiguous reads.
- 4x4 map with window {-3,-8,-1,-5} at outputs 0..3:
  - without POOL_RELU_EN: data -1;
  - with POOL_RELU_EN: data 0.
- Default 24x24 map, all 127 except one -128:
  - 144 writes, addr 0..143;
  - last write T+578, pool_fin T+579;
  - busy high T+1..T+578.
- Abort: pool_en dropped at cycle T+10 of a 4x4 pass:
  - IDLE next cycle, rd_en=wr_en=0;
  - no pool_fin;
  - a fresh pool_en then completes a full 4-write pass.
- Reset: rst_n=0 for 1 cycle mid-RUN:
  - all outputs zero on the next edge;
  - no pool_fin;
  - rst_n asserted asynchronously between edges has no effect until the edge.
- Back-to-back: pool_en held high through DONE:
  - exactly one pool_fin pulse;
  - IDLE, then RUN restarts the next cycle with rd_addr=0.
